bus_rr_arbiter: RTL and testbench
=================================

# bus_rr_arbiter

Round-robin bus arbiter for the four bus-master channels, upstream of the master multiplexer, address decoder and slave read-data/ready multiplexer. It owns bus ownership: registers one-hot active-low grants from the masters' requests and holds the grant for the whole tenure. It also watches the shared address strobe against the multiplexed slave ready. A transfer whose slave never answers within a fixed window is terminated by a timeout that forcibly revokes the grant.

## Interface
- `MASTER_CH`, 4: number of bus masters. The design is fixed at 4, so the owner index is 2 bits.
- `TIMEOUT`, 16: number of consecutive wait cycles that triggers a timeout. Legal range is 2..2^`TMO_W`-1.
- `TMO_W`, 5: width of the wait counter.
- `clk`, in, 1: clock.
- `reset_`, in, 1: one clock; reset is synchronous and active-low.
- `m_req_`, in, 4: per-master bus request, active-low.
- `m_as_`, in, 1: shared address strobe after the master multiplexer, active-low.
- `m_rdy_`, in, 1: shared ready from the slave multiplexer, active-low.
- `m_grnt_`, out, 4: per-master grant, active-low, registered, at most one bit low.
- `bus_owner`, out, 2: index of the current or last owner, registered.
- `bus_tmo`, out, 1: one-cycle active-high pulse on timeout.
- `tmo_owner`, out, 2: index of the master that last timed out. Holds its value until the next timeout.

## Operation
- States:
  - IDLE: no grant.
  - BUSY: grant held by `bus_owner`.
  - RECOVER: one dead cycle after a timeout.
- Reset values (`reset_` low at a rising edge):
  - state = IDLE
  - `m_grnt_` = 4'b1111
  - `bus_owner` = 0
  - `bus_tmo` = 0
  - `tmo_owner` = 0
  - wait counter = 0
- Reset mid-tenure takes effect on that edge; the grant drops immediately.
- Round-robin selection: search the requesters in the order `bus_owner`+1, +2, +3, then `bus_owner` itself, all modulo 4. The first one found with `m_req_` low wins.
- IDLE:
  - If any `m_req_` is low, select a winner, set `bus_owner` to the winner, drive its `m_grnt_` bit low, and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, owner keeps its request low (bit `bus_owner` of `m_req_` is low): hold the grant. No preemption by other requests.
- BUSY, owner releases (bit `bus_owner` of `m_req_` is high):
  - If another master is requesting, select the next owner and switch the grant on the same edge, with no dead cycle.
  - If no master is requesting, go to IDLE with all grants high.
- Wait counter, in BUSY only:
  - Increments when `m_as_` is low and `m_rdy_` is high.
  - Clears to 0 when `m_rdy_` is low, when `m_as_` is high, on any ownership change, and in IDLE/RECOVER.
- Timeout: in BUSY, when the counter equals `TIMEOUT`-1 and the current cycle is still a wait cycle:
  - Pulse `bus_tmo` next cycle.
  - Load `tmo_owner` with `bus_owner`.
  - Drive all grants high.
  - Clear the counter.
  - Go to RECOVER.
  - Timeout takes priority over a same-cycle owner release.
- RECOVER: lasts exactly one cycle, with grants high. Arbitration then proceeds as in IDLE on the next edge, with search order starting at the timed-out owner+1. The timed-out master is re-granted only if it is the sole requester.
- `bus_owner` is unchanged in IDLE and RECOVER.

## Timing
- Request-to-grant latency, from IDLE: 1 clock. A request low before edge N gives the grant low after edge N.
- Handoff latency: 1 clock. The release is sampled at edge N; the new grant is valid after edge N, with zero dead cycles.
- Timeout:
  - The first wait cycle is sampled at edge k, so the counter reads 1 after edge k.
  - `bus_tmo` goes high and grants go high after edge k+`TIMEOUT`-1.
  - `bus_tmo` is high for exactly one cycle.
  - The earliest re-grant follows 2 edges later.
- Invariant: never more than one `m_grnt_` bit low. Verify with an assertion every cycle.

## Test plan
- Reset, then all requests high for 5 cycles:
  - `m_grnt_` = 4'b1111, `bus_owner` = 0, `bus_tmo` = 0 throughout.
- After reset, `m_req_` = 4'b1010 (masters 0 and 2 requesting):
  - Next cycle `m_grnt_` = 4'b1011 and `bus_owner` = 2, because search order is 1, 2, 3, 0.
- Master 2 owns the bus and releases while `m_req_` = 4'b0110 (masters 0 and 3 requesting):
  - Next cycle `m_grnt_` = 4'b0111 (master 3 granted), with no dead cycle.
  - Master 3 then releases with only master 0 requesting: `m_grnt_` = 4'b1110.
- Master 1 owns the bus, `m_as_` low, `m_rdy_` held high, `TIMEOUT` = 16:
  - `bus_tmo` pulses one cycle, 15 edges after the first wait edge.
  - `tmo_owner` = 1 and grants go 4'b1111.
  - With master 1 as the sole requester, it is re-granted 2 cycles later.
- Same as the previous scenario, but `m_rdy_` goes low on wait cycle 15:
  - No timeout; the counter clears and the grant is held.
- Master 3 owns the bus mid-transfer and `reset_` is low for 1 cycle:
  - All outputs reach reset values on that edge.
  - Arbitration restarts from owner 0.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - four-master round-robin bus arbiter with transfer timeout
//
// Ports:
//   clk        clock
//   reset_     synchronous active-low reset
//   m_req_     per-master bus request, active-low
//   m_as_      shared address strobe (post master mux), active-low
//   m_rdy_     shared slave ready (post slave mux), active-low
//   m_grnt_    per-master grant, active-low, registered, at most one low
//   bus_owner  index of the current or most recent owner
//   bus_tmo    one-cycle pulse when a transfer times out
//   tmo_owner  index of the master that last timed out
module bus_rr_arbiter #(
    parameter int MASTER_CH = 4,
    parameter int TIMEOUT   = 16,
    parameter int TMO_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset_,
    input  logic [MASTER_CH-1:0] m_req_,
    input  logic                 m_as_,
    input  logic                 m_rdy_,
    output logic [MASTER_CH-1:0] m_grnt_,
    output logic [1:0]           bus_owner,
    output logic                 bus_tmo,
    output logic [1:0]           tmo_owner
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(TIMEOUT - 1);

    state_t                 state_q;
    logic [MASTER_CH-1:0]   grnt_q;
    logic [1:0]             owner_q;
    logic                   tmo_q;
    logic [1:0]             tmo_owner_q;
    logic [TMO_W-1:0]       cnt_q;

    logic                   win_found;
    logic [1:0]             win_idx;
    logic [1:0]             cand;
    logic                   wait_cyc;

    // Search owner+1, +2, +3 and finally owner itself; the 2-bit add wraps
    // naturally, so i == 4 lands back on the owner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = owner_q;
        cand      = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = owner_q + 2'(i);
            if (!win_found && !m_req_[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // A wait cycle is an address phase the selected slave has not answered.
    assign wait_cyc = !m_as_ && m_rdy_;

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q     <= IDLE;
            grnt_q      <= '1;
            owner_q     <= 2'd0;
            tmo_q       <= 1'b0;
            tmo_owner_q <= 2'd0;
            cnt_q       <= '0;
        end else begin
            tmo_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (win_found) begin
                        owner_q <= win_idx;
                        grnt_q  <= ~(MASTER_CH'(1) << win_idx);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // Timeout wins over a release sampled on the same edge.
                    if (wait_cyc && (cnt_q == CNT_LAST)) begin
                        tmo_q       <= 1'b1;
                        tmo_owner_q <= owner_q;
                        grnt_q      <= '1;
                        cnt_q       <= '0;
                        state_q     <= RECOVER;
                    end else if (m_req_[owner_q]) begin
                        // Owner's own bit is high here, so it cannot re-win.
                        cnt_q <= '0;
                        if (win_found) begin
                            owner_q <= win_idx;
                            grnt_q  <= ~(MASTER_CH'(1) << win_idx);
                        end else begin
                            grnt_q  <= '1;
                            state_q <= IDLE;
                        end
                    end else if (wait_cyc) begin
                        cnt_q <= cnt_q + TMO_W'(1);
                    end else begin
                        cnt_q <= '0;
                    end
                end
                RECOVER: begin
                    // Dead cycle; owner_q still names the timed-out master so
                    // the following IDLE search starts just past it.
                    cnt_q   <= '0;
                    grnt_q  <= '1;
                    state_q <= IDLE;
                end
                default: begin
                    cnt_q   <= '0;
                    grnt_q  <= '1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_grnt_   = grnt_q;
    assign bus_owner = owner_q;
    assign bus_tmo   = tmo_q;
    assign tmo_owner = tmo_owner_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb/tb_bus_rr_arbiter.sv - self-checking bench for bus_rr_arbiter
module tb_bus_rr_arbiter;

    localparam int TIMEOUT = 16;

    logic       clk    = 1'b0;
    logic       reset_ = 1'b0;
    logic [3:0] m_req_ = 4'hF;
    logic       m_as_  = 1'b1;
    logic       m_rdy_ = 1'b1;
    logic [3:0] m_grnt_;
    logic [1:0] bus_owner;
    logic       bus_tmo;
    logic [1:0] tmo_owner;

    int errors = 0;
    int checks = 0;
    bit inv_en = 1'b0;

    // Reference state: who owns the bus, whether a grant is out, whether the
    // dead cycle after a timeout is pending, and the current wait-run length.
    int mo_owner     = 0;
    bit mo_granted   = 1'b0;
    bit mo_recover   = 1'b0;
    int mo_wait      = 0;
    bit mo_tmo       = 1'b0;
    int mo_tmo_owner = 0;

    always #5 clk = ~clk;

    bus_rr_arbiter #(.MASTER_CH(4), .TIMEOUT(TIMEOUT), .TMO_W(5)) dut (
        .clk       (clk),
        .reset_    (reset_),
        .m_req_    (m_req_),
        .m_as_     (m_as_),
        .m_rdy_    (m_rdy_),
        .m_grnt_   (m_grnt_),
        .bus_owner (bus_owner),
        .bus_tmo   (bus_tmo),
        .tmo_owner (tmo_owner)
    );

    always @(negedge clk) begin
        if (inv_en) begin
            checks++;
            assert ($countones(~m_grnt_) <= 1)
            else begin
                errors++;
                $error("FAIL onehot observed=%b required=at most one low", m_grnt_);
            end
        end
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int from, input logic [3:0] req);
        for (int i = 1; i <= 4; i++) begin
            int c = (from + i) % 4;
            if (req[c] == 1'b0) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_grant();
        logic [3:0] g = 4'hF;
        if (mo_granted) g[mo_owner] = 1'b0;
        return g;
    endfunction

    task automatic model_edge(input logic rst, input logic [3:0] req,
                              input logic as_n, input logic rdy_n);
        int  w;
        bit  waiting;
        waiting = (as_n == 1'b0) && (rdy_n == 1'b1);
        mo_tmo = 1'b0;
        if (!rst) begin
            mo_owner = 0; mo_granted = 0; mo_recover = 0;
            mo_wait = 0; mo_tmo_owner = 0;
        end else if (mo_recover) begin
            mo_recover = 0;
            mo_wait = 0;
        end else if (!mo_granted) begin
            mo_wait = 0;
            w = pick(mo_owner, req);
            if (w >= 0) begin
                mo_owner = w;
                mo_granted = 1;
            end
        end else if (waiting && mo_wait == TIMEOUT - 1) begin
            mo_tmo = 1;
            mo_tmo_owner = mo_owner;
            mo_granted = 0;
            mo_recover = 1;
            mo_wait = 0;
        end else if (req[mo_owner]) begin
            mo_wait = 0;
            w = pick(mo_owner, req);
            if (w >= 0) mo_owner = w;
            else mo_granted = 0;
        end else begin
            mo_wait = waiting ? mo_wait + 1 : 0;
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] req,
                        input logic as_n, input logic rdy_n);
        reset_ = rst;
        m_req_ = req;
        m_as_  = as_n;
        m_rdy_ = rdy_n;
        @(posedge clk);
        model_edge(rst, req, as_n, rdy_n);
        #1;
        chk("grant", m_grnt_, exp_grant());
        chk("owner", {2'b00, bus_owner}, 4'(mo_owner));
        chk("tmo", {3'b000, bus_tmo}, {3'b000, mo_tmo});
        chk("tmo_owner", {2'b00, tmo_owner}, 4'(mo_tmo_owner));
    endtask

    initial begin
        logic [3:0] rq;
        logic       ra;
        logic       rr;
        logic       rs;
        bit         stuck;

        // Reset then quiet bus.
        step(1'b0, 4'hF, 1'b1, 1'b1);
        inv_en = 1'b1;
        step(1'b0, 4'hF, 1'b1, 1'b1);
        chk("rst_grant", m_grnt_, 4'b1111);
        chk("rst_owner", {2'b00, bus_owner}, 4'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'hF, 1'b1, 1'b1);
            chk("idle_grant", m_grnt_, 4'b1111);
            chk("idle_tmo", {3'b000, bus_tmo}, 4'd0);
        end

        // Masters 0 and 2 request: search 1,2,3,0 picks 2.
        step(1'b1, 4'b1010, 1'b1, 1'b1);
        chk("first_grant", m_grnt_, 4'b1011);
        chk("first_owner", {2'b00, bus_owner}, 4'd2);
        step(1'b1, 4'b1010, 1'b1, 1'b1);
        chk("hold_grant", m_grnt_, 4'b1011);

        // Master 2 releases with 0 and 3 requesting: 3 wins, no dead cycle.
        step(1'b1, 4'b0110, 1'b1, 1'b1);
        chk("handoff_3", m_grnt_, 4'b0111);
        step(1'b1, 4'b1110, 1'b1, 1'b1);
        chk("handoff_0", m_grnt_, 4'b1110);

        // Hand to master 1.
        step(1'b1, 4'b1101, 1'b1, 1'b1);
        chk("owner1_grant", m_grnt_, 4'b1101);

        // Stuck slave: timeout on the 16th consecutive wait sample.
        for (int i = 1; i <= TIMEOUT; i++) begin
            step(1'b1, 4'b1101, 1'b0, 1'b1);
            chk("tmo_pulse", {3'b000, bus_tmo}, (i == TIMEOUT) ? 4'd1 : 4'd0);
        end
        chk("tmo_owner1", {2'b00, tmo_owner}, 4'd1);
        chk("tmo_revoke", m_grnt_, 4'b1111);
        step(1'b1, 4'b1101, 1'b1, 1'b1);
        chk("recover_grant", m_grnt_, 4'b1111);
        chk("tmo_single", {3'b000, bus_tmo}, 4'd0);
        step(1'b1, 4'b1101, 1'b1, 1'b1);
        chk("regrant1", m_grnt_, 4'b1101);

        // Ready arrives on the edge that would otherwise time out.
        for (int i = 1; i <= TIMEOUT + 4; i++) begin
            step(1'b1, 4'b1101, 1'b0, (i == TIMEOUT) ? 1'b0 : 1'b1);
            chk("no_tmo", {3'b000, bus_tmo}, 4'd0);
            chk("no_tmo_hold", m_grnt_, 4'b1101);
        end
        step(1'b1, 4'b1101, 1'b1, 1'b1);

        // Master 3 mid-transfer, then reset.
        step(1'b1, 4'b0111, 1'b1, 1'b1);
        chk("owner3_grant", m_grnt_, 4'b0111);
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0111, 1'b0, 1'b1);
        step(1'b0, 4'b0111, 1'b0, 1'b1);
        chk("midrst_grant", m_grnt_, 4'b1111);
        chk("midrst_owner", {2'b00, bus_owner}, 4'd0);
        chk("midrst_tmo", {3'b000, bus_tmo}, 4'd0);
        step(1'b1, 4'b1010, 1'b1, 1'b1);
        chk("post_rst_owner", {2'b00, bus_owner}, 4'd2);

        // Randomized traffic against the model.
        for (int seg = 0; seg < 40; seg++) begin
            stuck = ($urandom_range(0, 2) == 0);
            rq = 4'($urandom);
            for (int c = 0; c < 20; c++) begin
                if (stuck) begin
                    ra = 1'b0; rr = 1'b1; rs = 1'b1;
                end else begin
                    rq = 4'($urandom);
                    ra = 1'($urandom_range(0, 1));
                    rr = ($urandom_range(0, 3) != 0);
                    rs = ($urandom_range(0, 63) != 0);
                end
                step(rs, rq, ra, rr);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
